// File: rtl/pipelined_rca_pkg.sv
// Shared configuration for the pipelined ripple-carry adder: defaults, segment width and the
// legality check applied to WIDTH/STAGES at elaboration.
package pipelined_rca_pkg;

   localparam int unsigned DEF_WIDTH  = 32;
   localparam int unsigned DEF_STAGES = 4;

   function automatic int unsigned seg_w(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/pipelined_rca_if.sv
// Operand/result handshake bundle of the pipelined ripple-carry adder.
// PIPELINED_RCA_OVERFLOW_EN adds the ovf result bit.
interface pipelined_rca_if
   import pipelined_rca_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPELINED_RCA_OVERFLOW_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, x, y, cin, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef PIPELINED_RCA_OVERFLOW_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, x, y, cin, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef PIPELINED_RCA_OVERFLOW_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/pipelined_rca_segment.sv
// Combinational W-bit ripple chain of full adders; one instance per pipeline stage.
module rca_segment #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co = c[W];

endmodule

// File: rtl/pipelined_rca.sv
// WIDTH-bit adder split into STAGES registered ripple segments with a global-stall handshake.
// Define PIPELINED_RCA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_rca
   import pipelined_rca_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned STAGES = DEF_STAGES
) (
   input logic            clk,
   input logic            rst,
   pipelined_rca_if.slave bus
);

   localparam int unsigned SEG_W = seg_w(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_bad
      $fatal(1, "pipelined_rca: WIDTH must be a non-zero multiple of STAGES");
   end

   logic adv;
   logic last_v;

   // Single stall signal: every stage moves together or not at all.
   assign adv          = ~last_v | bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned DONE_W = (k + 1) * SEG_W;
      localparam int unsigned REST_W = WIDTH - DONE_W;

      logic [SEG_W-1:0]  a, b, s_seg;
      logic              ci, co, v_in;
      logic [DONE_W-1:0] s_d;
      logic [DONE_W-1:0] s_q;
      logic              v_q, c_q;

      if (k == 0) begin : g_head
         assign a    = bus.x[SEG_W-1:0];
         assign b    = bus.y[SEG_W-1:0];
         assign ci   = bus.cin;
         assign v_in = bus.in_valid;
         assign s_d  = s_seg;
      end else begin : g_body
         assign a    = g_stage[k-1].g_skew.xr_q[SEG_W-1:0];
         assign b    = g_stage[k-1].g_skew.yr_q[SEG_W-1:0];
         assign ci   = g_stage[k-1].c_q;
         assign v_in = g_stage[k-1].v_q;
         // Lower sum bits finished by earlier stages ride along (deskew).
         assign s_d  = {s_seg, g_stage[k-1].s_q};
      end

      rca_segment #(
         .W (SEG_W)
      ) u_seg (
         .a  (a),
         .b  (b),
         .ci (ci),
         .s  (s_seg),
         .co (co)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            c_q <= co;
            s_q <= s_d;
         end
      end

      // Operand bits not yet consumed wait here (skew).
      if (k < STAGES - 1) begin : g_skew
         logic [REST_W-1:0] xr_d, yr_d, xr_q, yr_q;

         if (k == 0) begin : g_src_bus
            assign xr_d = bus.x[WIDTH-1:SEG_W];
            assign yr_d = bus.y[WIDTH-1:SEG_W];
         end else begin : g_src_stage
            assign xr_d = g_stage[k-1].g_skew.xr_q[REST_W+SEG_W-1:SEG_W];
            assign yr_d = g_stage[k-1].g_skew.yr_q[REST_W+SEG_W-1:SEG_W];
         end

         always_ff @(posedge clk) begin
            if (adv) begin
               xr_q <= xr_d;
               yr_q <= yr_d;
            end
         end
      end
   end

   assign last_v        = g_stage[STAGES-1].v_q;
   assign bus.out_valid = last_v;
   assign bus.sum       = g_stage[STAGES-1].s_q;
   assign bus.cout      = g_stage[STAGES-1].c_q;

`ifdef PIPELINED_RCA_OVERFLOW_EN
   logic ovf_d, ovf_q;

   // Carry into the MSB is s ^ a ^ b at that bit; overflow is it XOR carry out.
   assign ovf_d = g_stage[STAGES-1].a[SEG_W-1] ^ g_stage[STAGES-1].b[SEG_W-1]
                ^ g_stage[STAGES-1].s_seg[SEG_W-1] ^ g_stage[STAGES-1].co;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: directed vectors, stream/stall/reset sequences and a
// randomized scoreboard run on 32/4, 8/1 and 8/8 configurations.
module tb_pipelined_rca;
   import pipelined_rca_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipelined_rca_if #(.WIDTH(32)) ia ();
   pipelined_rca_if #(.WIDTH(8))  ib ();
   pipelined_rca_if #(.WIDTH(8))  ic ();

   pipelined_rca #(.WIDTH(32), .STAGES(4)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   pipelined_rca #(.WIDTH(8),  .STAGES(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
   pipelined_rca #(.WIDTH(8),  .STAGES(8)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t tbl[9];

   int checks = 0;
   int errors = 0;

   logic [32:0] qa[$];
   logic [8:0]  qb[$];
   logic [8:0]  qc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] sx[5];
      logic [31:0] sy[5];
      logic [32:0] se[5];
      logic [31:0] rx, ry;
      logic        rc;
      int          n;
      int          popped;

      tbl[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
      tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[6] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
      tbl[7] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0};
      tbl[8] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

      ia.in_valid = 1'b0; ia.x = '0; ia.y = '0; ia.cin = 1'b0; ia.out_ready = 1'b1;
      ib.in_valid = 1'b0; ib.x = '0; ib.y = '0; ib.cin = 1'b0; ib.out_ready = 1'b1;
      ic.in_valid = 1'b0; ic.x = '0; ic.y = '0; ic.cin = 1'b0; ic.out_ready = 1'b1;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_sum", ia.sum, 0);
      chk("rst_cout", ia.cout, 0);
      chk("rst_in_ready", ia.in_ready, 1);
      chk("rst_b_out_valid", ib.out_valid, 0);
      chk("rst_c_out_valid", ic.out_valid, 0);
      tick();

      // Directed vectors, one at a time, with exact latency check
      for (int i = 0; i < 9; i++) begin
         ia.in_valid = 1'b1; ia.x = tbl[i].x; ia.y = tbl[i].y; ia.cin = tbl[i].cin;
         ia.out_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", i), ia.in_ready, 1);
         tick();
         ia.in_valid = 1'b0;
         for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_valid_c%0d", i, c), ia.out_valid, (c == 4));
            if (c < 4) tick();
         end
         chk($sformatf("vec%0d_sum", i), ia.sum, tbl[i].sum);
         chk($sformatf("vec%0d_cout", i), ia.cout, tbl[i].cout);
`ifdef PIPELINED_RCA_OVERFLOW_EN
         chk($sformatf("vec%0d_ovf", i), ia.ovf, tbl[i].ovf);
`endif
         tick();
      end

      // Back-to-back stream of 100 adds
      n = 0;
      for (int c = 0; c < 106; c++) begin
         if (c < 100) begin
            ia.in_valid = 1'b1; ia.x = 32'(c); ia.y = 32'(2 * c); ia.cin = c[0];
         end else begin
            ia.in_valid = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("stream_valid_c%0d", c), ia.out_valid, (c >= 4 && c < 104));
         if (ia.out_valid) begin
            chk($sformatf("stream_sum_%0d", n), {ia.cout, ia.sum}, 33'(3 * n + (n % 2)));
            n++;
         end
         tick();
      end
      chk("stream_count", n, 100);

      // Stall with a full pipe and a fifth add waiting at the input
      for (int j = 0; j < 5; j++) begin
         sx[j] = 32'h1111_1111 * (j + 1);
         sy[j] = 32'hF000_0000 + j;
         se[j] = {1'b0, sx[j]} + {1'b0, sy[j]};
      end
      for (int c = 0; c < 20; c++) begin
         ia.in_valid  = (c <= 14);
         ia.x         = sx[(c < 4) ? c : 4];
         ia.y         = sy[(c < 4) ? c : 4];
         ia.cin       = 1'b0;
         ia.out_ready = !(c >= 4 && c < 14);
         @(negedge clk);
         if (c < 4) begin
            chk($sformatf("stall_fill_valid_c%0d", c), ia.out_valid, 0);
         end else if (c < 14) begin
            chk($sformatf("stall_in_ready_c%0d", c), ia.in_ready, 0);
            chk($sformatf("stall_valid_c%0d", c), ia.out_valid, 1);
            chk($sformatf("stall_hold_c%0d", c), {ia.cout, ia.sum}, se[0]);
         end else if (c < 19) begin
            chk($sformatf("drain_valid_c%0d", c), ia.out_valid, 1);
            chk($sformatf("drain_res_c%0d", c), {ia.cout, ia.sum}, se[c-14]);
            if (c == 14) chk("release_in_ready", ia.in_ready, 1);
         end else begin
            chk("drain_empty", ia.out_valid, 0);
         end
         tick();
      end

      // Reset with two stages occupied
      for (int c = 0; c < 2; c++) begin
         ia.in_valid = 1'b1; ia.x = 32'(100 + c); ia.y = 32'd1; ia.cin = 1'b0;
         tick();
      end
      ia.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", ia.in_ready, 1);
      chk("midrst_valid", ia.out_valid, 0);
      chk("midrst_sum_clear", ia.sum, 0);
      ia.in_valid = 1'b1; ia.x = 32'd5; ia.y = 32'd7; ia.cin = 1'b0;
      tick();
      ia.in_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_valid_c%0d", c), ia.out_valid, (c == 4));
         if (c == 4) chk("midrst_sum", {ia.cout, ia.sum}, 33'd12);
         tick();
      end

      // Randomized traffic on all three configurations, then drain
      popped = 0;
      for (int c = 0; c < 1200; c++) begin
         rx = $urandom; ry = $urandom; rc = 1'($urandom_range(0, 1));
         ia.in_valid  = (c < 1000) && ($urandom_range(0, 3) != 0);
         ia.out_ready = (c >= 1000) || ($urandom_range(0, 3) != 0);
         ia.x = rx; ia.y = ry; ia.cin = rc;
         ib.in_valid  = (c < 1000) && ($urandom_range(0, 3) != 0);
         ib.out_ready = (c >= 1000) || ($urandom_range(0, 2) != 0);
         ib.x = rx[7:0]; ib.y = ry[7:0]; ib.cin = rc;
         ic.in_valid  = (c < 1000) && ($urandom_range(0, 3) != 0);
         ic.out_ready = (c >= 1000) || ($urandom_range(0, 2) != 0);
         ic.x = rx[15:8]; ic.y = ry[15:8]; ic.cin = ~rc;
         @(negedge clk);
         if (ia.out_valid && ia.out_ready) begin
            if (qa.size() == 0) chk("rand_a_spurious", 1, 0);
            else chk("rand_a", {ia.cout, ia.sum}, qa.pop_front());
            popped++;
         end
         if (ia.in_valid && ia.in_ready) qa.push_back({1'b0, ia.x} + {1'b0, ia.y} + 33'(ia.cin));
         if (ib.out_valid && ib.out_ready) begin
            if (qb.size() == 0) chk("rand_b_spurious", 1, 0);
            else chk("rand_b", {ib.cout, ib.sum}, qb.pop_front());
            popped++;
         end
         if (ib.in_valid && ib.in_ready) qb.push_back({1'b0, ib.x} + {1'b0, ib.y} + 9'(ib.cin));
         if (ic.out_valid && ic.out_ready) begin
            if (qc.size() == 0) chk("rand_c_spurious", 1, 0);
            else chk("rand_c", {ic.cout, ic.sum}, qc.pop_front());
            popped++;
         end
         if (ic.in_valid && ic.in_ready) qc.push_back({1'b0, ic.x} + {1'b0, ic.y} + 9'(ic.cin));
         tick();
      end
      chk("rand_a_left", qa.size(), 0);
      chk("rand_b_left", qb.size(), 0);
      chk("rand_c_left", qc.size(), 0);
      chk("rand_some_traffic", (popped > 1000), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
